mux_sign_pipe: RTL
==================

MUX_SIGN_PIPE -- requirements
Module: mux_sign_pipe

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the lane data width in bits (two's complement, W >= 2).
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of independent lanes.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-007 The block SHALL have port i0, input, LANES*W bits: source 0 words; lane k occupies bits [k*W+W-1 : k*W].
REQ-008 The block SHALL have port i1, input, LANES*W bits: source 1 words, packed as i0.
REQ-009 The block SHALL have port sel, input, LANES bits: per-lane source select; 0 selects i0, 1 selects i1.
REQ-010 The block SHALL have port mode, input, 2 bits: sign operation applied to all lanes of the beat.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the output beat.
REQ-013 The block SHALL have port out_data, output, LANES*W bits: result words, packed as i0.
REQ-014 The block SHALL have port neg_cnt, output, clog2(LANES+1) bits: count of lanes whose selected word was negative.
REQ-015 The block SHALL have port sat, output, LANES bits: per-lane saturation flag for the beat.

Function
REQ-016 Per lane, the selected word SHALL be x = sel[k] ? i1 lane k : i0 lane k.
REQ-017 Mode 00 (pass) SHALL output y = x.
REQ-018 Mode 01 (negate) SHALL output y = -x; x = -2^(W-1) SHALL saturate to 2^(W-1)-1 with sat[k]=1.
REQ-019 Mode 10 (abs) SHALL output y = |x|, with the same saturation rule as negate.
REQ-020 Mode 11 (relu) SHALL output y = 0 if the MSB of x is 1, else x.
REQ-021 sat[k] SHALL be 0 in all cases not covered by REQ-018/REQ-019.
REQ-022 neg_cnt SHALL equal the popcount of the MSBs of the selected x words, independent of mode.
REQ-023 A beat SHALL be accepted on a rising edge where in_valid && in_ready; sel and mode are sampled on that edge.
REQ-024 A beat SHALL be consumed on a rising edge where out_valid && out_ready.
REQ-025 Results SHALL be computed at acceptance and stored in a 2-entry FIFO holding out_data, neg_cnt and sat.
REQ-026 Latency SHALL be 1 cycle: a beat accepted into an empty FIFO is presented with out_valid=1 immediately after that edge.
REQ-027 in_ready SHALL equal (occupancy < 2) and SHALL NOT depend combinationally on in_valid or out_ready.
REQ-028 Occupancy SHALL be 0 (EMPTY), 1 (ONE) or 2 (FULL). Transitions: accept only +1; consume only -1; accept and consume together leaves occupancy unchanged.
REQ-029 Beats SHALL leave the block in acceptance order, with none dropped or duplicated.
REQ-030 While out_valid=1 and out_ready=0, out_data, neg_cnt and sat SHALL hold stable.
REQ-031 In FULL, in_valid SHALL be ignored; a same-cycle consume SHALL take effect and occupancy SHALL become ONE.
REQ-032 out_data, neg_cnt and sat SHALL be 0 whenever out_valid=0.

Reset
REQ-033 On rst_n=0, the block SHALL immediately clear occupancy to EMPTY and force out_valid=0, out_data=0, neg_cnt=0 and sat=0, without waiting for clk.
REQ-034 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 from the first rising edge after rst_n deasserts.
REQ-035 A reset asserted mid-stream SHALL discard all buffered beats; none SHALL appear after reset.

Verification (W=8, LANES=4)
REQ-036 Pass/select: mode=00, i0=0x80_7F_01_FF, i1=0x05_06_07_08, sel=0101 -> out_data=0x80_06_01_08, neg_cnt=1, sat=0000.
REQ-037 Negate saturation: mode=01, sel=0000, i0=0x80_FF_00_7F -> out_data=0x7F_01_00_81, sat=1000, neg_cnt=2.
REQ-038 Abs and relu: i0=0x80_FE_02_00 with mode=10 -> 0x7F_02_02_00, sat=1000; same i0 with mode=11 -> 0x00_00_02_00, sat=0000.
REQ-039 Backpressure: out_ready=0 while three beats A,B,C are offered -> A and B accepted, in_ready=0 and C held; raise out_ready -> outputs A,B,C in order with no loss.
REQ-040 Simultaneous accept and consume at ONE for 10 consecutive cycles -> occupancy stays ONE, one beat out per cycle, order preserved.
REQ-041 rst_n pulsed low asynchronously mid-cycle while FULL -> out_valid=0 and outputs 0 before the next edge; in_ready=1 after the first edge following release.

Source files
------------

// File: rtl/mux_sign_pipe.sv
// Per-lane 2:1 select followed by a sign operation (pass/negate/abs/relu), with results
// buffered in a 2-entry FIFO behind a valid/ready handshake on both sides.
module mux_sign_pipe #(
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*W-1:0]             i0,
    input  logic [LANES*W-1:0]             i1,
    input  logic [LANES-1:0]               sel,
    input  logic [1:0]                     mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*W-1:0]             out_data,
    output logic [$clog2(LANES+1)-1:0]     neg_cnt,
    output logic [LANES-1:0]               sat
);

    localparam int unsigned CW = $clog2(LANES + 1);
    localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MaxVal = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

    occ_e                 state_q, state_d;
    logic                 rdy_en_q;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [LANES*W-1:0]   data_q [2];
    logic [CW-1:0]        neg_q  [2];
    logic [LANES-1:0]     sat_q  [2];

    logic [LANES*W-1:0]   res_data;
    logic [CW-1:0]        res_neg;
    logic [LANES-1:0]     res_sat;

    logic                 accept;
    logic                 consume;

    // in_ready comes only from registered state, so it never combinationally follows
    // in_valid or out_ready; rdy_en_q keeps it low until the first edge after reset.
    assign in_ready  = rdy_en_q && (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Lane select and sign operation on the incoming beat.
    always_comb begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] neg_x;
        x        = '0;
        y        = '0;
        neg_x    = '0;
        res_data = '0;
        res_neg  = '0;
        res_sat  = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            x     = sel[k] ? i1[k*W +: W] : i0[k*W +: W];
            neg_x = '0 - x;
            y     = x;
            case (mode)
                2'b00: y = x;
                2'b01: begin
                    if (x == MinVal) begin
                        y          = MaxVal;
                        res_sat[k] = 1'b1;
                    end else begin
                        y = neg_x;
                    end
                end
                2'b10: begin
                    if (x == MinVal) begin
                        y          = MaxVal;
                        res_sat[k] = 1'b1;
                    end else if (x[W-1]) begin
                        y = neg_x;
                    end else begin
                        y = x;
                    end
                end
                default: y = x[W-1] ? '0 : x;
            endcase
            res_data[k*W +: W] = y;
            res_neg            = res_neg + CW'(x[W-1]);
        end
    end

    // Occupancy next-state: accept adds one, consume removes one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StOne;
            StOne: begin
                if (accept && !consume)      state_d = StFull;
                else if (!accept && consume) state_d = StEmpty;
            end
            StFull:  if (consume) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    // Occupancy, pointers and post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            rdy_en_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (accept)  wr_ptr_q <= ~wr_ptr_q;
            if (consume) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // FIFO storage, written with the computed result on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) begin
                data_q[e] <= '0;
                neg_q[e]  <= '0;
                sat_q[e]  <= '0;
            end
        end else if (accept) begin
            data_q[wr_ptr_q] <= res_data;
            neg_q[wr_ptr_q]  <= res_neg;
            sat_q[wr_ptr_q]  <= res_sat;
        end
    end

    // Head of FIFO drives outputs; forced to zero when nothing is valid.
    always_comb begin
        out_data = '0;
        neg_cnt  = '0;
        sat      = '0;
        if (out_valid) begin
            out_data = data_q[rd_ptr_q];
            neg_cnt  = neg_q[rd_ptr_q];
            sat      = sat_q[rd_ptr_q];
        end
    end

endmodule
